// File: rtl/fwd_scoreboard.sv
// Operand forwarding network plus per-register pending-write scoreboard.
// Each source operand is taken from the youngest pipeline stage that writes
// it, or from the register file when no stage matches. The pending counters
// track in-flight writes that have left the forwarding window, so an operand
// whose producer is still pending but not visible in any stage stalls issue.
module fwd_scoreboard #(
    parameter int DW   = 32,
    parameter int AW   = 5,
    parameter int NSTG = 4,
    parameter int CW   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 issue_valid,
    output logic                 issue_ready,
    input  logic [AW-1:0]        issue_rj,
    input  logic [AW-1:0]        issue_rk,
    input  logic [AW-1:0]        issue_rd,
    input  logic                 issue_we,
    input  logic [DW-1:0]        rf_rj_data,
    input  logic [DW-1:0]        rf_rk_data,
    input  logic [NSTG-1:0]      stg_valid,
    input  logic [NSTG*AW-1:0]   stg_dest,
    input  logic [NSTG*DW-1:0]   stg_data,
    input  logic [NSTG-1:0]      stg_data_ok,
    input  logic                 retire_valid,
    input  logic                 retire_we,
    input  logic [AW-1:0]        retire_dest,
    output logic [DW-1:0]        rj_data,
    output logic [DW-1:0]        rk_data,
    output logic                 stall,
    output logic [31:0]          stall_cnt
);

    localparam int NREG = 1 << AW;
    localparam logic [CW-1:0] CMAX = '1;

    logic [CW-1:0]   r_pending [NREG];
    logic [31:0]     r_stall_cnt;

    logic            w_rjHit, w_rjRdy, w_rjUnready;
    logic            w_rkHit, w_rkRdy, w_rkUnready;
    logic [DW-1:0]   w_rjData, w_rkData;
    logic            w_rdFull, w_fire, w_incEn, w_decEn;
    logic [NREG-1:0] w_incVec, w_decVec;

    // Returns {hit, ready, data}. Scanning from the oldest stage down lets the
    // youngest match overwrite older ones, giving stage 0 the final say.
    // Register 0 is hardwired to zero and never matches any stage.
    function automatic logic [DW+1:0] srcLookup(
        input logic [AW-1:0]      src,
        input logic [NSTG-1:0]    vld,
        input logic [NSTG*AW-1:0] dst,
        input logic [NSTG*DW-1:0] dat,
        input logic [NSTG-1:0]    ok,
        input logic [DW-1:0]      rf
    );
        logic          hit;
        logic          rdy;
        logic [DW-1:0] d;
        hit = 1'b0;
        rdy = 1'b1;
        d   = rf;
        for (int i = NSTG - 1; i >= 0; i--) begin
            if (vld[i] && (dst[i*AW +: AW] == src)) begin
                hit = 1'b1;
                rdy = ok[i];
                d   = dat[i*DW +: DW];
            end
        end
        if (src == '0) begin
            hit = 1'b0;
            rdy = 1'b1;
            d   = '0;
        end
        return {hit, rdy, d};
    endfunction

    // Source selection and readiness for both operands.
    always_comb begin
        {w_rjHit, w_rjRdy, w_rjData} = srcLookup(issue_rj, stg_valid, stg_dest,
                                                 stg_data, stg_data_ok, rf_rj_data);
        {w_rkHit, w_rkRdy, w_rkData} = srcLookup(issue_rk, stg_valid, stg_dest,
                                                 stg_data, stg_data_ok, rf_rk_data);
        w_rjUnready = w_rjHit ? ~w_rjRdy : (r_pending[issue_rj] != '0);
        w_rkUnready = w_rkHit ? ~w_rkRdy : (r_pending[issue_rk] != '0);
    end

    // Issue handshake: a destination whose counter is already full must wait
    // for a retire, otherwise the counter would wrap and lose a write.
    always_comb begin
        w_rdFull    = issue_we && (issue_rd != '0) && (r_pending[issue_rd] == CMAX);
        stall       = issue_valid & (w_rjUnready | w_rkUnready);
        issue_ready = ~stall & ~w_rdFull & ~flush;
        w_fire      = issue_valid & issue_ready;
        w_incEn     = w_fire & issue_we & (issue_rd != '0);
        w_decEn     = retire_valid & retire_we & (retire_dest != '0);
    end

    // One-hot increment/decrement requests; a decrement of an empty counter
    // is dropped here so it can neither wrap nor cancel a same-cycle issue.
    always_comb begin
        w_incVec = '0;
        w_decVec = '0;
        if (w_incEn) begin
            w_incVec[issue_rd] = 1'b1;
        end
        if (w_decEn && (r_pending[retire_dest] != '0)) begin
            w_decVec[retire_dest] = 1'b1;
        end
    end

    // Pending counters: reset beats flush, flush beats issue/retire, and a
    // matched increment and decrement on one register cancel out.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            for (int r = 0; r < NREG; r++) begin
                r_pending[r] <= '0;
            end
        end else begin
            r_pending[0] <= '0;
            for (int r = 1; r < NREG; r++) begin
                case ({w_incVec[r], w_decVec[r]})
                    2'b10:   r_pending[r] <= r_pending[r] + 1'b1;
                    2'b01:   r_pending[r] <= r_pending[r] - 1'b1;
                    default: r_pending[r] <= r_pending[r];
                endcase
            end
        end
    end

    // Saturating count of stalled issue cycles; survives flush, not reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign rj_data   = w_rjData;
    assign rk_data   = w_rkData;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: doc/fwd_scoreboard.md
FWD_SCOREBOARD -- requirements
Module: fwd_scoreboard

Interface
REQ-001 SHALL have parameter DW, default 32, datapath width.
REQ-002 SHALL have parameter AW, default 5, register address width; NREG = 2^AW.
REQ-003 SHALL have parameter NSTG, default 4, number of forwarding source stages; index 0 is youngest and has highest priority.
REQ-004 SHALL have parameter CW, default 2, pending-counter width; max in-flight writes per register = 2^CW-1.
REQ-005 clk  input  1  sole clock, all state on rising edge.
REQ-006 reset  input  1  synchronous, active-high.
REQ-007 flush  input  1  pipeline flush; clears all pending state.
REQ-008 issue_valid  input  1  decode stage presents an instruction.
REQ-009 issue_ready  output  1  instruction may issue this cycle.
REQ-010 issue_rj, issue_rk  input  AW each  source register addresses.
REQ-011 issue_rd  input  AW  destination register; issue_we  input  1  writes rd.
REQ-012 rf_rj_data, rf_rk_data  input  DW each  register-file read data.
REQ-013 stg_valid  input  NSTG  stage holds a valid writing instruction.
REQ-014 stg_dest  input  NSTG*AW  per-stage destination, stage i at bits [i*AW +: AW].
REQ-015 stg_data  input  NSTG*DW  per-stage result, stage i at [i*DW +: DW].
REQ-016 stg_data_ok  input  NSTG  stage result is available (0 e.g. for load awaiting memory).
REQ-017 retire_valid, retire_we  input  1 each; retire_dest  input  AW  writeback commit.
REQ-018 rj_data, rk_data  output  DW each  forwarded operands.
REQ-019 stall  output  1  operand not yet available.
REQ-020 stall_cnt  output  32  saturating count of cycles with issue_valid & stall.

Function
REQ-021 Fire SHALL be issue_valid & issue_ready; issue_ready = ~stall & ~rd_full & ~flush.
REQ-022 rd_full SHALL be 1 when issue_we, issue_rd != 0 and pending[issue_rd] == 2^CW-1.
REQ-023 Source rj SHALL match stage i when stg_valid[i] and stg_dest[i] == issue_rj and issue_rj != 0; same for rk.
REQ-024 rj_data SHALL be stg_data of lowest-index matching stage; if none, rf_rj_data; if issue_rj == 0, zero; same for rk. Combinational, zero latency.
REQ-025 A source SHALL be unready when its selected stage has stg_data_ok = 0, or when no stage matches but pending[src] != 0.
REQ-026 stall SHALL be issue_valid & (rj unready | rk unready); stall SHALL be 0 when issue_valid = 0.
REQ-027 On fire with issue_we and issue_rd != 0, pending[issue_rd] SHALL increment at next edge.
REQ-028 On retire_valid & retire_we and retire_dest != 0, pending[retire_dest] SHALL decrement at next edge; decrement of a zero counter SHALL be ignored (no wrap).
REQ-029 Simultaneous increment and decrement of the same register SHALL leave its counter unchanged; different registers update independently.
REQ-030 pending[0] SHALL remain 0 permanently; register 0 never stalls or forwards.
REQ-031 flush SHALL clear all counters at next edge and override any same-cycle issue or retire update.
REQ-032 stall_cnt SHALL increment by 1 per cycle with issue_valid & stall, saturate at 32'hFFFFFFFF, and is not cleared by flush.

Reset
REQ-033 reset SHALL clear all pending counters and stall_cnt to 0 at the next edge, taking priority over flush, issue and retire.
REQ-034 Combinational outputs SHALL depend only on inputs and state; after reset issue_ready = 1 and stall = 0 when no stage matches.
REQ-035 Reset asserted mid-operation SHALL discard all in-flight pending state; no retire after reset decrements below 0.

Verification
REQ-036 Priority: stg_valid=4'b0110, stg_dest stage1=stage2=5, data 0x11/0x22, data_ok=1, issue_rj=5 -> rj_data=0x11, stall=0.
REQ-037 Load-use: stage0 dest=7, data_ok=0, issue_rk=7, issue_valid=1 -> stall=1, issue_ready=0, stall_cnt +1 per cycle; data_ok->1 -> stall=0 same cycle.
REQ-038 Register 0: issue_rj=0, stage0 dest=0 data 0xDEAD -> rj_data=0, no stall; issuing rd=0 leaves pending[0]=0.
REQ-039 Saturation (CW=2): three fires with rd=3 and no retire -> fourth issue with rd=3 sees issue_ready=0; one retire dest=3 -> issue_ready=1 next cycle.
REQ-040 Simultaneous: pending[4]=1, fire rd=4 and retire dest=4 same cycle -> pending[4]=1; then flush with concurrent fire rd=4 -> all counters 0.
REQ-041 Reset mid-run: counters nonzero, stall_cnt=9, reset 1 cycle -> counters 0, stall_cnt=0, source with no stage match gives stall=0.
